mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, max consecutive dcache grants while icache is pending before icache is forced next.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 nRST  in  1  reset, asynchronous and active-low.
REQ-004 iREN  in  1  icache read request.
REQ-005 iaddr  in  32  icache word address.
REQ-006 dREN  in  1  dcache read request.
REQ-007 dWEN  in  1  dcache write request.
REQ-008 daddr  in  32  dcache word address.
REQ-009 dstore  in  32  dcache write data.
REQ-010 ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-011 ramload  in  32  RAM read data.
REQ-012 iwait  out  1  high while icache request is not yet complete.
REQ-013 iload  out  32  instruction word to icache.
REQ-014 dwait  out  1  high while dcache request is not yet complete.
REQ-015 dload  out  32  data word to dcache.
REQ-016 ramREN, ramWEN  out  1 each  RAM read/write enables.
REQ-017 ramaddr, ramstore  out  32 each  RAM address/write data.

Function
REQ-018 FSM states: IDLE, IGNT, DGNT; state and a 3-bit starvation counter (scnt) are registered.
REQ-019 IDLE: no RAM enables; iwait=iREN, dwait=(dREN|dWEN).
REQ-020 IDLE -> DGNT when (dREN|dWEN) and not (iREN and scnt>=STARVE_MAX); else IDLE -> IGNT when iREN; else stay.
REQ-021 Grant decision is made in IDLE; RAM enables first assert the cycle after the request is seen (1-cycle arbitration latency).
REQ-022 IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr; iload=ramload; dwait=(dREN|dWEN).
REQ-023 DGNT: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins if dREN and dWEN both high); else ramREN=1; dload=ramload.
REQ-024 Completion: in IGNT/DGNT, when ramstate==ACCESS the granted requester's wait is 0 that same cycle (combinational), and the FSM returns to IDLE next cycle.
REQ-025 ramstate FREE, BUSY or ERROR in a grant state: granted wait stays 1, enables held, FSM stays (ERROR = retry).
REQ-026 Abort: granted requester deasserts its request(s) before ACCESS -> RAM enables drop that cycle, FSM to IDLE next cycle, no completion.
REQ-027 scnt: increments (saturating at 7) on each DGNT completion while iREN is high; clears to 0 on IGNT completion or when iREN is low in IDLE.
REQ-028 Non-granted requester always sees wait=1 while requesting; its load output is don't-care (drive ramload).
REQ-029 When no state drives them, ramaddr/ramstore/iload/dload = 0 or ramload respectively; outputs never X after reset.
REQ-030 Only one of ramREN/ramWEN is ever high in a cycle.

Reset
REQ-031 nRST low asynchronously forces state=IDLE, scnt=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-032 Reset asserted mid-transaction abandons it; after release, requesters still high re-arbitrate from IDLE.

Verification
REQ-033 Reset, no requests -> ramREN=ramWEN=0, iwait=dwait=0, state IDLE.
REQ-034 iREN=1, iaddr=0x40, ramstate ACCESS on 2nd grant cycle, ramload=0xDEADBEEF -> ramREN=1 from cycle 1, iwait=0 and iload=0xDEADBEEF in cycle 2.
REQ-035 iREN and dWEN together, daddr=0x80, dstore=0x1234 -> DGNT first (ramWEN=1, ramstore=0x1234), then IGNT after completion.
REQ-036 iREN held, dREN re-asserted continuously, each access 1-cycle ACCESS -> exactly 4 dcache grants, then 1 icache grant, pattern repeats.
REQ-037 DGNT with ramstate BUSY 3 cycles then ERROR 1 then ACCESS -> dwait=1 for 4 cycles, 0 on ACCESS cycle.
REQ-038 dREN dropped in DGNT before ACCESS -> ramREN=0 same cycle, IDLE next cycle; nRST pulse mid-IGNT -> ramREN=0 immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: icache reads and dcache reads/writes share one RAM port.
// dcache normally wins; a starvation counter forces icache after STARVE_MAX dcache grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [3:0] LP_SMAX   = 4'(STARVE_MAX);

  state_t     r_state;
  logic [2:0] r_scnt;

  logic w_dreq, w_access, w_istarve;

  assign w_dreq    = dREN | dWEN;
  assign w_access  = (ramstate == RS_ACCESS);
  assign w_istarve = iREN && ({1'b0, r_scnt} >= LP_SMAX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_scnt  <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!iREN) r_scnt <= 3'd0;
          if (w_dreq && !w_istarve) r_state <= DGNT;
          else if (iREN)            r_state <= IGNT;
        end
        IGNT: begin
          // Dropping the request before ACCESS abandons the grant.
          if (!iREN) r_state <= IDLE;
          else if (w_access) begin
            r_state <= IDLE;
            r_scnt  <= 3'd0;
          end
        end
        DGNT: begin
          if (!w_dreq) r_state <= IDLE;
          else if (w_access) begin
            r_state <= IDLE;
            if (iREN && r_scnt != 3'd7) r_scnt <= r_scnt + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load paths are don't-care outside their grant, so they just follow the RAM.
  assign iload = ramload;
  assign dload = ramload;

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = iREN;
    dwait    = w_dreq;
    case (r_state)
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = iREN && !w_access;
      end
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = w_dreq && !w_access;
      end
      default: ;
    endcase
  end

endmodule
